// File: rtl/dcm_lock_supervisor_pkg.sv
// Shared definitions for the DCM lock supervisor.
//   state_e   : encoded supervisor state, also driven out on state_o
//   cnt_width : width of a counter able to hold the largest of three cycle counts
package dcm_lock_supervisor_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StReset    = 3'd1,
        StWaitLock = 3'd2,
        StSettle   = 3'd3,
        StReload   = 3'd4,
        StLocked   = 3'd5,
        StFail     = 3'd6,
        StFault    = 3'd7
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dcm_lock_supervisor_sync_2ff.sv
// Generic two-flop synchroniser with a synchronous reset value.
//   clk_i   : destination clock
//   reset_i : synchronous active-high reset, loads RESET_VAL into both stages
//   d_i     : asynchronous input
//   q_o     : synchronised output, two cycles after d_i
module dcm_lock_supervisor_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dcm_lock_supervisor.sv
// DCM lock supervisor: resets the DCM, waits for and qualifies lock, re-applies the phase
// shift and escalates to a sticky fault after a bounded number of failed attempts.
//   clk_i / reset_i   : control clock, synchronous active-high reset
//   enable_i          : low forces IDLE
//   use_ext_clk_i     : rising edge restarts the DCM bring-up
//   dcm_locked_i      : asynchronous lock indication (synchronised here)
//   phase_value_i     : phase shift to re-apply after lock; zero skips the reload
//   phase_done_i      : phase-shift completion pulse
//   clear_fault_i     : leaves FAULT with the retry count cleared
//   dcm_reset_o       : DCM reset request
//   phase_load_o      : one-cycle phase-load strobe
//   locked_o/fault_o  : status, registered
//   state_o           : current state encoding
//   relock_count_o    : saturating count of lock losses seen in LOCKED
module dcm_lock_supervisor
    import dcm_lock_supervisor_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
    parameter int unsigned SETTLE_CYC       = 256,
    parameter int unsigned MAX_RETRIES      = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       use_ext_clk_i,
    input  logic       dcm_locked_i,
    input  logic [8:0] phase_value_i,
    input  logic       phase_done_i,
    output logic       dcm_reset_o,
    output logic       phase_load_o,
    output logic       locked_o,
    output logic       fault_o,
    output logic [2:0] state_o,
    output logic [7:0] relock_count_o,
    input  logic       clear_fault_i
);

    localparam int unsigned CntW = cnt_width(LOCK_TIMEOUT_CYC, SETTLE_CYC, RST_PULSE_CYC);
    localparam logic [CntW-1:0] RstLast     = CntW'(RST_PULSE_CYC - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYC - 1);
    localparam logic [CntW-1:0] CntMax      = {CntW{1'b1}};
    localparam logic [7:0]      MaxRetries  = 8'(MAX_RETRIES);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      retry_q, retry_d;
    logic [7:0]      relock_q, relock_d;
    logic            ext_q;
    logic            lk;
    logic            ext_edge;
    logic            restart;
    logic            dcm_reset_q, dcm_reset_d;
    logic            phase_load_q, phase_load_d;
    logic            locked_q, locked_d;
    logic            fault_q, fault_d;

    dcm_lock_supervisor_sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (dcm_locked_i),
        .q_o     (lk)
    );

    assign ext_edge = use_ext_clk_i & ~ext_q;

    // State register and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            retry_q      <= '0;
            relock_q     <= '0;
            ext_q        <= 1'b0;
            dcm_reset_q  <= 1'b1;
            phase_load_q <= 1'b0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            relock_q     <= relock_d;
            ext_q        <= use_ext_clk_i;
            dcm_reset_q  <= dcm_reset_d;
            phase_load_q <= phase_load_d;
            locked_q     <= locked_d;
            fault_q      <= fault_d;
        end
    end

    // Next state and counters
    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        restart  = 1'b0;

        case (state_q)
            StIdle: begin
                if (enable_i) state_d = StReset;
            end
            StReset: begin
                if (cnt_q == RstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (lk)                        state_d = StSettle;
                else if (cnt_q == TimeoutLast) state_d = StFail;
            end
            StSettle: begin
                if (!lk) begin
                    state_d = StFail;
                end else if (cnt_q == SettleLast) begin
                    state_d = (phase_value_i != '0) ? StReload : StLocked;
                end
            end
            StReload: begin
                // Lock loss outranks a simultaneous phase_done
                if (!lk)                       state_d = StFail;
                else if (phase_done_i)         state_d = StLocked;
                else if (cnt_q == TimeoutLast) state_d = StFail;
            end
            StLocked: begin
                retry_d = '0;
                if (!lk) begin
                    relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
                    state_d  = StReset;
                end
            end
            StFail: begin
                retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                state_d = (retry_d >= MaxRetries) ? StFault : StReset;
            end
            StFault: begin
                if (clear_fault_i) begin
                    retry_d = '0;
                    state_d = StReset;
                end
            end
            default: state_d = StIdle;
        endcase

        // Overrides discard whatever the state itself decided, counters included
        if (!enable_i) begin
            state_d  = StIdle;
            retry_d  = retry_q;
            relock_d = relock_q;
        end else if (ext_edge && state_q != StIdle && state_q != StFault) begin
            state_d  = StReset;
            retry_d  = retry_q;
            relock_d = relock_q;
            restart  = 1'b1;
        end

        // Cleared on every state entry, including a forced re-entry of RESET
        if (state_d != state_q || restart) cnt_d = '0;
        else if (cnt_q == CntMax)          cnt_d = cnt_q;
        else                               cnt_d = cnt_q + 1'b1;
    end

    // Outputs decoded from the next state so the registers line up with state_q
    always_comb begin
        dcm_reset_d  = 1'b0;
        phase_load_d = 1'b0;
        locked_d     = 1'b0;
        fault_d      = 1'b0;
        case (state_d)
            StIdle, StReset: dcm_reset_d = 1'b1;
            StReload:        phase_load_d = (state_q != StReload);
            StLocked:        locked_d = 1'b1;
            StFault: begin
                fault_d     = 1'b1;
                dcm_reset_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign dcm_reset_o    = dcm_reset_q;
    assign phase_load_o   = phase_load_q;
    assign locked_o       = locked_q;
    assign fault_o        = fault_q;
    assign state_o        = state_q;
    assign relock_count_o = relock_q;

endmodule
